puf_host_initiator: RTL and testbench
=====================================

# puf_host_initiator

Host-side protocol engine for the PUF challenge/response link: the initiator that talks to the PUF device's main state machine over a UART byte channel. On `start` it sends the ID-request byte, checks the returned ID byte, sends one challenge byte, then collects `RESP_BYTES` response bytes and streams them out. It sits between a UART TX/RX pair and a host-side consumer, such as a self-test harness or a CRP logger. Timeout and ID-mismatch detection ensure a dead or foreign device never hangs the host.

## Interface
- `DATA_BITS`, 8, UART byte width (fixed at 8)
- `ID_REQ_BYTE`, 8'h49, byte sent to request the device ID
- `EXPECTED_ID`, 8'hA5, ID byte the device must return
- `RESP_BYTES`, 4, number of response bytes per challenge (1..255)
- `TIMEOUT_CYCLES`, 100000, maximum idle cycles allowed between expected RX bytes (≥2)

- `clk` in 1 global clock
- `reset` in 1 synchronous, active-high reset
- `start` in 1 request a transaction; accepted only when `busy`=0
- `challenge` in 8 challenge byte, sampled on the cycle `start` is accepted
- `tx_busy` in 1 UART TX busy
- `tx_start` out 1 one-cycle pulse that launches a UART byte
- `tx_data` out 8 byte to transmit, valid while `tx_start`=1
- `rx_valid` in 1 one-cycle strobe for a received byte
- `rx_data` in 8 received byte, valid with `rx_valid`
- `resp_valid` out 1 one-cycle strobe for a response byte
- `resp_data` out 8 response byte
- `resp_last` out 1 high with the final `resp_valid`
- `busy` out 1 transaction in progress
- `done` out 1 one-cycle pulse on successful completion
- `error` out 1 sticky failure flag
- `error_code` out 2 01 = ID mismatch, 10 = timeout, 00 = none

## Operation
- States: IDLE, SEND_REQ, WAIT_ID, SEND_CHAL, WAIT_RESP.
- IDLE: `busy`=0. When `start`=1:
  - latch `challenge`
  - clear `error` and `error_code`
  - go to SEND_REQ
- SEND_REQ: wait for a cycle with `tx_busy`=0. Then register `tx_start`=1 and `tx_data`=`ID_REQ_BYTE`, and go to WAIT_ID.
- WAIT_ID: on `rx_valid`:
  - if `rx_data`==`EXPECTED_ID`, go to SEND_CHAL
  - otherwise set `error`=1 and `error_code`=01, and go to IDLE
- SEND_CHAL: wait for a cycle with `tx_busy`=0. Then register `tx_start`=1 and `tx_data`=latched challenge. Clear the byte counter and go to WAIT_RESP.
- WAIT_RESP: on each `rx_valid`:
  - register `resp_valid`=1 and `resp_data`=`rx_data`
  - increment the counter
  - on byte number `RESP_BYTES`, also assert `resp_last`=1 and `done`=1, and go to IDLE
- Timeout counter:
  - cleared on entry to WAIT_ID/WAIT_RESP and on every accepted `rx_valid`
  - increments every other cycle spent in those states
  - on reaching `TIMEOUT_CYCLES`-1 with no `rx_valid`, set `error`=1 and `error_code`=10, and go to IDLE
- A same-cycle `rx_valid` wins over the timeout.
- `rx_valid` in IDLE, SEND_REQ or SEND_CHAL is ignored and produces no output.
- `start` while `busy`=1 is ignored, and the latched challenge is unchanged.
- `error` and `error_code` hold until the next accepted `start`. `done` is never asserted on a failed transaction.
- Counter widths: byte counter is $clog2(RESP_BYTES+1) bits; timeout counter is $clog2(TIMEOUT_CYCLES) bits. Neither wraps: both are cleared before reaching their limit.

## Timing
- All outputs are registered. Reset values:
  - `tx_start`=0, `tx_data`=0
  - `resp_valid`=0, `resp_data`=0, `resp_last`=0
  - `busy`=0, `done`=0
  - `error`=0, `error_code`=00
  - state IDLE
- `reset` asserted mid-transaction aborts it within one cycle. No `tx_start`, `resp_valid` or `done` appears in the cycle after reset is sampled.
- Start latency: `start` accepted in cycle N (IDLE) → `busy`=1 in N+1. With `tx_busy`=0, `tx_start` pulses in N+2.
- If `tx_busy`=1, `tx_start` is deferred until the cycle after `tx_busy` is first sampled low. `tx_start` never lasts more than one cycle.
- `rx_valid` in cycle M → `resp_valid` in M+1.
- On the final response byte, `resp_valid`, `resp_last` and `done` are all high in M+1, with `busy`=0 in M+1.
- Error: `error` goes high and `busy` goes low in the cycle after the offending `rx_valid` or the timeout compare.
- A new `start` may be accepted in the same cycle that `done` is high.

## Test plan
- Nominal run (`challenge`=8'h3C, device returns A5 then 11,22,33,44):
  - TX sequence is 49 then 3C
  - four `resp_valid` strobes carry 11,22,33,44
  - `resp_last` and `done` are high only with 44
  - `error`=0
- ID mismatch (device returns 8'h5A): `error`=1, `error_code`=01, no second `tx_start`, `busy`=0 the next cycle.
- Timeout (`TIMEOUT_CYCLES`=16, device sends two response bytes then stops):
  - two `resp_valid` strobes
  - `error_code`=10 exactly 16 cycles after the second byte
  - `done` stays 0
- `tx_busy` held high for 20 cycles after `start`: `tx_start` pulses once, one cycle after `tx_busy` falls.
- Back-to-back requests:
  - `start` with `challenge`=8'h77 pulsed again while `busy` is ignored, and the TX challenge stays 8'h3C
  - `start` in the `done` cycle is accepted
- `reset` asserted during WAIT_RESP after one byte: all outputs return to reset values, and a following nominal run completes correctly.

Source files
------------

// File: rtl/puf_host_initiator.sv
// Host-side initiator for the PUF challenge/response link over a UART byte channel.
// Latency: start -> busy +1 cycle, -> tx_start +2 cycles; rx_valid -> resp_valid +1 cycle.
// Backpressure: each TX launch waits for tx_busy low; RX has no backpressure, and a silent device ends the transaction with a timeout.
// Ports: clk/reset (sync, active-high); start/challenge request a transaction;
//   tx_busy/tx_start/tx_data drive the UART TX; rx_valid/rx_data come from the UART RX;
//   resp_valid/resp_data/resp_last stream the response; busy/done/error/error_code report status.
module puf_host_initiator #(
  parameter int                   DATA_BITS      = 8,
  parameter logic [DATA_BITS-1:0] ID_REQ_BYTE    = 8'h49,
  parameter logic [DATA_BITS-1:0] EXPECTED_ID    = 8'hA5,
  parameter int                   RESP_BYTES     = 4,
  parameter int                   TIMEOUT_CYCLES = 100000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] challenge,
  input  logic                 tx_busy,
  output logic                 tx_start,
  output logic [DATA_BITS-1:0] tx_data,
  input  logic                 rx_valid,
  input  logic [DATA_BITS-1:0] rx_data,
  output logic                 resp_valid,
  output logic [DATA_BITS-1:0] resp_data,
  output logic                 resp_last,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [1:0]           error_code
);

  localparam int BCW = $clog2(RESP_BYTES + 1);
  localparam int TOW = $clog2(TIMEOUT_CYCLES);
  localparam logic [BCW-1:0] LAST_IDX = BCW'(RESP_BYTES - 1);
  localparam logic [TOW-1:0] TO_LIMIT = TOW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_ID   = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_SEND_REQ, S_WAIT_ID, S_SEND_CHAL, S_WAIT_RESP
  } state_t;

  state_t state_q, state_d;

  logic [DATA_BITS-1:0] chal_q, chal_d;
  logic [BCW-1:0]       byte_cnt_q, byte_cnt_d;
  logic [TOW-1:0]       tmo_q, tmo_d;

  logic                 tx_start_q, tx_start_d;
  logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
  logic                 resp_valid_q, resp_valid_d;
  logic [DATA_BITS-1:0] resp_data_q, resp_data_d;
  logic                 resp_last_q, resp_last_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;
  logic [1:0]           error_code_q, error_code_d;

  // Timeout fires only on a cycle without rx_valid, so a same-cycle byte wins.
  logic tmo_hit;
  assign tmo_hit = (tmo_q == TO_LIMIT);

  logic last_byte;
  assign last_byte = (byte_cnt_q == LAST_IDX);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (start) state_d = S_SEND_REQ;
      S_SEND_REQ:  if (!tx_busy) state_d = S_WAIT_ID;
      S_WAIT_ID: begin
        if (rx_valid)     state_d = (rx_data == EXPECTED_ID) ? S_SEND_CHAL : S_IDLE;
        else if (tmo_hit) state_d = S_IDLE;
      end
      S_SEND_CHAL: if (!tx_busy) state_d = S_WAIT_RESP;
      S_WAIT_RESP: begin
        if (rx_valid)     begin if (last_byte) state_d = S_IDLE; end
        else if (tmo_hit) state_d = S_IDLE;
      end
      default:     state_d = S_IDLE;
    endcase
  end

  // Output / datapath next-state logic; every output is registered below.
  always_comb begin
    chal_d       = chal_q;
    byte_cnt_d   = byte_cnt_q;
    tmo_d        = tmo_q;
    tx_start_d   = 1'b0;
    tx_data_d    = tx_data_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    resp_last_d  = 1'b0;
    done_d       = 1'b0;
    error_d      = error_q;
    error_code_d = error_code_q;
    busy_d       = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          chal_d       = challenge;
          error_d      = 1'b0;
          error_code_d = ERR_NONE;
        end
      end
      S_SEND_REQ: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = ID_REQ_BYTE;
          tmo_d      = '0;
        end
      end
      S_WAIT_ID: begin
        if (rx_valid) begin
          tmo_d = '0;
          if (rx_data != EXPECTED_ID) begin
            error_d      = 1'b1;
            error_code_d = ERR_ID;
          end
        end else if (tmo_hit) begin
          error_d      = 1'b1;
          error_code_d = ERR_TMO;
        end else begin
          tmo_d = tmo_q + TOW'(1);
        end
      end
      S_SEND_CHAL: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = chal_q;
          byte_cnt_d = '0;
          tmo_d      = '0;
        end
      end
      S_WAIT_RESP: begin
        if (rx_valid) begin
          tmo_d        = '0;
          resp_valid_d = 1'b1;
          resp_data_d  = rx_data;
          if (last_byte) begin
            resp_last_d = 1'b1;
            done_d      = 1'b1;
            byte_cnt_d  = '0;
          end else begin
            byte_cnt_d = byte_cnt_q + BCW'(1);
          end
        end else if (tmo_hit) begin
          error_d      = 1'b1;
          error_code_d = ERR_TMO;
        end else begin
          tmo_d = tmo_q + TOW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      chal_q       <= '0;
      byte_cnt_q   <= '0;
      tmo_q        <= '0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_last_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      error_code_q <= ERR_NONE;
    end else begin
      chal_q       <= chal_d;
      byte_cnt_q   <= byte_cnt_d;
      tmo_q        <= tmo_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_last_q  <= resp_last_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      error_code_q <= error_code_d;
    end
  end

  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_last  = resp_last_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign error_code = error_code_q;

endmodule

// File: tb/tb_puf_host_initiator.sv
// Bench for puf_host_initiator: an emulated PUF device answers each request, and
// every output event is logged with its cycle number and compared against the
// transaction-level expectations derived from the link protocol.
module tb_puf_host_initiator;
  localparam int RB = 4;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] challenge = 8'h00;
  logic       tx_busy = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       resp_valid;
  logic [7:0] resp_data;
  logic       resp_last;
  logic       busy;
  logic       done;
  logic       error;
  logic [1:0] error_code;

  puf_host_initiator #(
    .RESP_BYTES(RB),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .challenge(challenge),
    .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_last(resp_last),
    .busy(busy), .done(done), .error(error), .error_code(error_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event log, appended only here.
  logic [7:0] tx_b[$];
  int         tx_c[$];
  logic [7:0] rs_b[$];
  logic       rs_l[$];
  int         rs_c[$];
  int         done_c[$];
  int         err_c[$];
  logic [1:0] err_cd[$];
  logic       err_bz[$];
  logic       prev_err = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      if (tx_start) begin tx_b.push_back(tx_data); tx_c.push_back(cyc); end
      if (resp_valid) begin rs_b.push_back(resp_data); rs_l.push_back(resp_last); rs_c.push_back(cyc); end
      if (done) done_c.push_back(cyc);
      if (error && !prev_err) begin
        err_c.push_back(cyc); err_cd.push_back(error_code); err_bz.push_back(busy);
      end
    end
    prev_err <= error;
  end

  int n_vec = 0;
  int n_bad = 0;
  int chain_n = 0;
  bit fixed_resp = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_tx_start"},   tx_start,   0);
    chk({tag, "_tx_data"},    tx_data,    0);
    chk({tag, "_resp_valid"}, resp_valid, 0);
    chk({tag, "_resp_data"},  resp_data,  0);
    chk({tag, "_resp_last"},  resp_last,  0);
    chk({tag, "_busy"},       busy,       0);
    chk({tag, "_done"},       done,       0);
    chk({tag, "_error"},      error,      0);
    chk({tag, "_error_code"}, error_code, 0);
  endtask

  // One transaction: drive start, play the device, then compare the logged
  // events with what the protocol rules predict for this scenario.
  task automatic run_txn(input logic [7:0] chal, input logic [7:0] dev_id, input int n_send,
                         input int busy_len, input bit extra_start, input int rst_after,
                         input bit chain_out, input logic [7:0] chain_chal, input bit pre_started);
    int n, k, g, t2, t0, n_exp;
    int b_tx, b_rs, b_dn, b_er;
    logic [7:0] sent[$];
    int rxc[$];
    logic [1:0] exp_code;
    bit id_ok, chained, exp_done;
    id_ok   = (dev_id == 8'hA5);
    chained = chain_out && id_ok && (n_send == RB);
    b_tx = tx_b.size(); b_rs = rs_b.size(); b_dn = done_c.size(); b_er = err_c.size();
    t2 = 0;

    if (!pre_started) begin
      k = 0;
      while (busy && k < 60) begin tick(); k++; end
      chk("idle_before_start", busy, 0);
      start = 1'b1; challenge = chal; n = cyc;
      tick();
      start = 1'b0; challenge = 8'($urandom);
    end else begin
      n = chain_n;
    end
    chk("busy_after_start", busy, 1);
    chk("err_cleared", error, 0);

    // TX held busy; a stray RX byte during SEND_REQ must be ignored.
    for (int i = 0; i < busy_len; i++) begin
      tx_busy = 1'b1; rx_valid = (i == 1); rx_data = 8'($urandom);
      tick();
    end
    tx_busy = 1'b0; rx_valid = 1'b0;

    k = 0;
    while (!tx_start && k < 60) begin tick(); k++; end
    chk("req_seen", tx_start, 1);
    if (!tx_start) return;

    g = extra_start ? $urandom_range(1, 5) : $urandom_range(0, 5);
    for (int i = 0; i < g; i++) begin
      start = extra_start && (i == 0); challenge = 8'h77;
      tick();
    end
    start = 1'b0;
    rx_valid = 1'b1; rx_data = dev_id; rxc.push_back(cyc);
    tick();
    rx_valid = 1'b0; rx_data = 8'($urandom);

    if (id_ok) begin
      k = 0;
      while (!tx_start && k < 60) begin tick(); k++; end
      chk("chal_seen", tx_start, 1);
      if (!tx_start) return;
      t2 = cyc;
      for (int j = 0; j < n_send; j++) begin
        g = $urandom_range(0, 6);
        repeat (g) tick();
        rx_valid = 1'b1;
        rx_data  = fixed_resp ? 8'(8'h11 * (j + 1)) : 8'($urandom);
        sent.push_back(rx_data); rxc.push_back(cyc);
        tick();
        rx_valid = 1'b0;
        if (rst_after == j + 1) begin
          reset = 1'b1;
          tick();
          chk_reset_vals("mid_reset");
          reset = 1'b0;
          tick();
          chk("post_reset_idle", busy, 0);
          return;
        end
        if (chained && j == n_send - 1) begin
          start = 1'b1; challenge = chain_chal; chain_n = cyc;
          tick();
          start = 1'b0;
        end
      end
    end

    if (!chained) begin
      k = 0;
      while (busy && k < 60) begin tick(); k++; end
      chk("busy_drop", busy, 0);
      tick(); tick();
    end

    // Expected behaviour derived from the protocol rules.
    n_exp = id_ok ? 2 : 1;
    chk("tx_count", tx_b.size() - b_tx, n_exp);
    if (tx_b.size() > b_tx) begin
      chk("tx_req_byte", tx_b[b_tx], 8'h49);
      chk("tx_req_cyc", tx_c[b_tx], n + 2 + busy_len);
    end
    if (id_ok && tx_b.size() > b_tx + 1) begin
      chk("tx_chal_byte", tx_b[b_tx + 1], chal);
      chk("tx_chal_cyc", tx_c[b_tx + 1], rxc[0] + 2);
    end

    n_exp = id_ok ? ((n_send < RB) ? n_send : RB) : 0;
    chk("resp_count", rs_b.size() - b_rs, n_exp);
    for (int i = 0; i < n_exp && b_rs + i < rs_b.size(); i++) begin
      chk("resp_data", rs_b[b_rs + i], sent[i]);
      chk("resp_last", rs_l[b_rs + i], (i == RB - 1));
      chk("resp_cyc",  rs_c[b_rs + i], rxc[i + 1] + 1);
    end

    exp_done = id_ok && (n_send == RB);
    chk("done_count", done_c.size() - b_dn, exp_done);
    if (exp_done && done_c.size() > b_dn) chk("done_cyc", done_c[b_dn], rxc[RB] + 1);

    exp_code = !id_ok ? 2'b01 : ((n_send < RB) ? 2'b10 : 2'b00);
    chk("err_events", err_c.size() - b_er, (exp_code != 2'b00));
    if (exp_code != 2'b00 && err_c.size() > b_er) begin
      chk("err_code", err_cd[b_er], exp_code);
      chk("err_busy", err_bz[b_er], 0);
      if (!id_ok) begin
        chk("id_err_cyc", err_c[b_er], rxc[0] + 1);
      end else begin
        t0 = (n_send == 0) ? t2 : rxc[n_send] + 1;
        chk("tmo_cyc", err_c[b_er], t0 + TO);
      end
    end
    if (!chained) chk("err_hold", {error, error_code}, {(exp_code != 2'b00), exp_code});
  endtask

  initial begin
    logic [7:0] dev, ch;
    int ns;
    reset = 1'b1;
    repeat (3) tick();
    chk_reset_vals("reset");
    reset = 1'b0;
    tick();

    fixed_resp = 1'b1;
    // Nominal run
    run_txn(8'h3C, 8'hA5, 4, 0, 1'b0, -1, 1'b0, 8'h00, 1'b0);
    // ID mismatch
    run_txn(8'h3C, 8'h5A, 4, 0, 1'b0, -1, 1'b0, 8'h00, 1'b0);
    // Timeout after two response bytes
    run_txn(8'h3C, 8'hA5, 2, 0, 1'b0, -1, 1'b0, 8'h00, 1'b0);
    // Timeout with no response bytes at all
    run_txn(8'h3C, 8'hA5, 0, 0, 1'b0, -1, 1'b0, 8'h00, 1'b0);
    // tx_busy held for 20 cycles
    run_txn(8'h3C, 8'hA5, 4, 20, 1'b0, -1, 1'b0, 8'h00, 1'b0);
    // Ignored start while busy, then a start in the done cycle
    run_txn(8'h3C, 8'hA5, 4, 0, 1'b1, -1, 1'b1, 8'h9E, 1'b0);
    run_txn(8'h9E, 8'hA5, 4, 0, 1'b0, -1, 1'b0, 8'h00, 1'b1);
    // Reset during WAIT_RESP after one byte, then a clean run
    run_txn(8'h3C, 8'hA5, 4, 0, 1'b0, 1, 1'b0, 8'h00, 1'b0);
    run_txn(8'h3C, 8'hA5, 4, 0, 1'b0, -1, 1'b0, 8'h00, 1'b0);

    fixed_resp = 1'b0;
    for (int t = 0; t < 25; t++) begin
      dev = 8'hA5;
      if ($urandom_range(0, 4) == 0) begin
        dev = 8'($urandom);
        if (dev == 8'hA5) dev = 8'h00;
      end
      ns = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 3) : RB;
      ch = 8'($urandom);
      run_txn(ch, dev, ns, $urandom_range(0, 4), 1'($urandom_range(0, 1)), -1, 1'b0, 8'h00, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
